// File: rtl/mdu_pkg.sv
// Shared RV32M encodings and mdu constants.
// Imported by decode and the mdu itself.
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply, restoring divide, shared acc.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int W2 = 2 * XLEN;

  mdu_state_t      r_state;
  logic [5:0]      r_cnt;
  logic [2:0]      r_f3;
  logic [W2-1:0]   r_acc;
  logic [XLEN-1:0] r_b;
  logic            r_neg;
  logic            r_div0;
  logic            r_done;
  logic [XLEN-1:0] r_res;
  logic [4:0]      r_rd;

  logic            w_a_sgn;
  logic            w_b_sgn;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_neg;
  logic            w_is_div;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem;
  logic [XLEN+1:0] w_diff;
  logic [W2-1:0]   w_step;
  logic [W2-1:0]   w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rmd;
  logic [XLEN-1:0] w_res;
  logic            w_last;

  // Operand sign handling at issue time.
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    unique case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        w_a_sgn = op_a[XLEN-1];
        w_b_sgn = op_b[XLEN-1];
      end
      F3_MULHSU: w_a_sgn = op_a[XLEN-1];
      default: ;
    endcase
    w_a_mag = w_a_sgn ? -op_a : op_a;
    w_b_mag = w_b_sgn ? -op_b : op_b;
    // Remainder follows the dividend only.
    w_neg = (funct3[2] & funct3[1]) ?
            w_a_sgn : (w_a_sgn ^ w_b_sgn);
  end

  // One multiply or divide iteration.
  always_comb begin
    w_is_div = r_f3[2];
    w_sum = {1'b0, r_acc[W2-1:XLEN]} +
            (r_acc[0] ? {1'b0, r_b} : '0);
    w_rem = {r_acc[W2-1:XLEN], r_acc[XLEN-1]};
    w_diff = {1'b0, w_rem} - {2'b0, r_b};
    w_step = '0;
    if (!w_is_div)
      w_step = {w_sum, r_acc[XLEN-1:1]};
    else if (!w_diff[XLEN+1])
      w_step = {w_diff[XLEN-1:0],
                r_acc[XLEN-2:0], 1'b1};
    else
      w_step = {w_rem[XLEN-1:0],
                r_acc[XLEN-2:0], 1'b0};
  end

  // Sign fix-up and final result selection.
  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo = r_neg ? -r_acc[XLEN-1:0]
                  : r_acc[XLEN-1:0];
    if (r_div0)
      w_quo = '1;
    w_rmd = r_neg ? -r_acc[W2-1:XLEN]
                  : r_acc[W2-1:XLEN];
    w_res = '0;
    unique case (r_f3)
      F3_MUL: w_res = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:
        w_res = w_prod[W2-1:XLEN];
      F3_DIV, F3_DIVU: w_res = w_quo;
      default: w_res = w_rmd;
    endcase
  end

  assign w_last = (r_cnt == 6'(MDU_ITER - 1));

  // Control FSM plus shared datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_f3    <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_neg   <= 1'b0;
      r_div0  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_rd    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_f3    <= funct3;
            r_rd    <= rd_in;
            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
            r_b     <= w_b_mag;
            r_neg   <= w_neg;
            r_div0  <= (op_b == '0);
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 6'd1;
            if (w_last)
              r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          if (!flush) begin
            r_done <= 1'b1;
            r_res  <= w_res;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE) | r_done;
  assign done   = r_done;
  assign result = r_res;
  assign rd_out = r_rd;

endmodule

// File: tb/tb_mdu.sv
// Directed vector bench for mdu.
// Table of ops plus handshake sequences.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;

  mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Issue one op; lat = edge index of done, -1 if none.
  task automatic run_op(input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        output logic [31:0] res,
                        output logic [4:0] rdo,
                        output int lat);
    funct3 = f; op_a = a; op_b = b;
    rd_in = rd; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1; res = 'x; rdo = 'x;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done && lat < 0) begin
        lat = k; res = result; rdo = rd_out;
      end
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] keep;
    logic [4:0]  rdo;
    int lat;
    int nd;
    int d1;
    int d2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  q1;
    logic [4:0]  q2;

    vecs[0]  = '{F3_MULHU,  32'hFFFFFFFF,
                 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE};
    vecs[1]  = '{F3_MUL,    32'hFFFFFFFF,
                 32'hFFFFFFFF, 5'd2, 32'h00000001};
    vecs[2]  = '{F3_MULH,   32'hFFFFFFFE,
                 32'd3, 5'd3, 32'hFFFFFFFF};
    vecs[3]  = '{F3_MULHSU, 32'hFFFFFFFF,
                 32'd2, 5'd4, 32'hFFFFFFFF};
    vecs[4]  = '{F3_MUL,    32'hFFFFFFF9,
                 32'd5, 5'd5, 32'hFFFFFFDD};
    vecs[5]  = '{F3_DIV,    32'hFFFFFFF9,
                 32'd2, 5'd6, 32'hFFFFFFFD};
    vecs[6]  = '{F3_REM,    32'hFFFFFFF9,
                 32'd2, 5'd7, 32'hFFFFFFFF};
    vecs[7]  = '{F3_DIVU,   32'd100,
                 32'd7, 5'd8, 32'd14};
    vecs[8]  = '{F3_REMU,   32'd100,
                 32'd7, 5'd9, 32'd2};
    vecs[9]  = '{F3_DIV,    32'd5,
                 32'd0, 5'd10, 32'hFFFFFFFF};
    vecs[10] = '{F3_REM,    32'd5,
                 32'd0, 5'd11, 32'd5};
    vecs[11] = '{F3_DIV,    32'h80000000,
                 32'hFFFFFFFF, 5'd12, 32'h80000000};
    vecs[12] = '{F3_REM,    32'h80000000,
                 32'hFFFFFFFF, 5'd13, 32'd0};
    vecs[13] = '{F3_DIV,    32'd7,
                 32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD};
    vecs[14] = '{F3_REM,    32'd7,
                 32'hFFFFFFFE, 5'd15, 32'd1};
    vecs[15] = '{F3_REM,    32'hFFFFFFF9,
                 32'd0, 5'd16, 32'hFFFFFFF9};
    vecs[16] = '{F3_MULH,   32'h80000000,
                 32'h80000000, 5'd0, 32'h40000000};
    vecs[17] = '{F3_MULHSU, 32'h80000000,
                 32'hFFFFFFFF, 5'd31, 32'h80000000};

    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b,
             vecs[i].rd, res, rdo, lat);
      chk($sformatf("v%0d_result", i),
          res, vecs[i].exp);
      chk($sformatf("v%0d_latency", i),
          32'(lat), 32'd33);
      chk($sformatf("v%0d_rd", i),
          32'(rdo), 32'(vecs[i].rd));
    end

    // busy window: high T..T+33, low after T+34
    funct3 = F3_MUL; op_a = 32'd6; op_b = 32'd7;
    rd_in = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_T", 32'(busy), 32'd1);
    for (int k = 1; k <= 33; k++) tick();
    chk("busy_T33", 32'(busy), 32'd1);
    chk("done_T33", 32'(done), 32'd1);
    chk("res_T33", result, 32'd42);
    tick();
    chk("busy_T34", 32'(busy), 32'd0);
    chk("done_T34", 32'(done), 32'd0);
    chk("hold_T34", result, 32'd42);

    // start pulsed mid-RUN is ignored
    funct3 = F3_MUL; op_a = 32'd9; op_b = 32'd9;
    rd_in = 5'd21; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    funct3 = F3_DIVU; op_a = 32'd100;
    op_b = 32'd7; rd_in = 5'd22; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0; res = '0; rdo = '0;
    for (int k = 11; k <= 80; k++) begin
      tick();
      if (done) begin
        nd++; res = result; rdo = rd_out;
      end
    end
    chk("midrun_ndone", 32'(nd), 32'd1);
    chk("midrun_result", res, 32'd81);
    chk("midrun_rd", 32'(rdo), 32'd21);

    // flush at T+10
    keep = result;
    funct3 = F3_MULHU; op_a = 32'hFFFFFFFF;
    op_b = 32'h12345678; rd_in = 5'd23;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_T10", 32'(busy), 32'd0);
    tick();
    chk("flush_busy_T11", 32'(busy), 32'd0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) nd++;
    end
    chk("flush_ndone", 32'(nd), 32'd0);
    chk("flush_result", result, keep);

    // flush beats start in IDLE
    funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd3;
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    tick();
    chk("flush_start_busy2", 32'(busy), 32'd0);

    // reset at T+5
    funct3 = F3_DIVU; op_a = 32'd1000;
    op_b = 32'd3; rd_in = 5'd24; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_rd", 32'(rd_out), 32'd0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) nd++;
    end
    chk("mrst_ndone", 32'(nd), 32'd0);

    // back-to-back with start held high
    funct3 = F3_MUL; op_a = 32'd11; op_b = 32'd13;
    rd_in = 5'd3; start = 1'b1;
    tick();
    funct3 = F3_DIVU; op_a = 32'd50;
    op_b = 32'd4; rd_in = 5'd9;
    d1 = -1; d2 = -1;
    r1 = '0; r2 = '0; q1 = '0; q2 = '0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (done) begin
        if (d1 < 0) begin
          d1 = k; r1 = result; q1 = rd_out;
        end else if (d2 < 0) begin
          d2 = k; r2 = result; q2 = rd_out;
        end
      end
    end
    start = 1'b0;
    chk("b2b_lat1", 32'(d1), 32'd33);
    chk("b2b_res1", r1, 32'd143);
    chk("b2b_rd1", 32'(q1), 32'd3);
    chk("b2b_lat2", 32'(d2), 32'd67);
    chk("b2b_res2", r2, 32'd12);
    chk("b2b_rd2", 32'(q2), 32'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("b2b_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
